// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - per-PC 2-bit saturating-counter branch history table
// ID side reads a prediction; EX side trains the table and requests a redirect on mispredict.
module branch_predictor #(
  parameter int         IDX_W      = 4,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_branch_i,
  input  logic [31:0] id_pc_i,
  output logic [1:0]  id_state_o,
  output logic        id_pred_taken_o,
  input  logic        ex_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic [1:0]  ex_state_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_pcplus4_i,
  input  logic [31:0] ex_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] br_count_o,
  output logic [31:0] miss_count_o
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       tbl_q [ENTRIES];
  logic [1:0]       tbl_d [ENTRIES];
  logic [31:0]      br_count_q, br_count_d;
  logic [31:0]      miss_count_q, miss_count_d;
  logic [IDX_W-1:0] id_idx, ex_idx;
  logic [1:0]       new_state;

  assign id_idx = id_pc_i[IDX_W+1:2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];

  // Training starts from the state carried down the pipe, so aliased writes are last-wins.
  always_comb begin
    new_state = ex_state_i;
    if (ex_taken_i) begin
      if (ex_state_i != 2'b11) new_state = ex_state_i + 2'd1;
    end else begin
      if (ex_state_i != 2'b00) new_state = ex_state_i - 2'd1;
    end
  end

  assign mispredict_o  = ex_branch_i & (ex_state_i[1] ^ ex_taken_i);
  assign redirect_pc_o = ex_taken_i ? ex_target_i : ex_pcplus4_i;

  // Forward the in-flight write so ID never sees a stale entry.
  assign id_state_o      = (ex_branch_i && (id_idx == ex_idx)) ? new_state : tbl_q[id_idx];
  assign id_pred_taken_o = id_state_o[1] & id_branch_i;

  assign br_count_o   = br_count_q;
  assign miss_count_o = miss_count_q;

  always_comb begin
    tbl_d        = tbl_q;
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (ex_branch_i) begin
      tbl_d[ex_idx] = new_state;
      if (br_count_q != 32'hFFFF_FFFF) br_count_d = br_count_q + 32'd1;
    end
    if (mispredict_o && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= INIT_STATE;
      br_count_q   <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      tbl_q        <= tbl_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_branch_i;
  logic [31:0] id_pc_i;
  logic [1:0]  id_state_o;
  logic        id_pred_taken_o;
  logic        ex_branch_i;
  logic [31:0] ex_pc_i;
  logic [1:0]  ex_state_i;
  logic        ex_taken_i;
  logic [31:0] ex_pcplus4_i;
  logic [31:0] ex_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] br_count_o;
  logic [31:0] miss_count_o;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.IDX_W(4), .INIT_STATE(2'b01)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_branch_i(id_branch_i), .id_pc_i(id_pc_i),
    .id_state_o(id_state_o), .id_pred_taken_o(id_pred_taken_o),
    .ex_branch_i(ex_branch_i), .ex_pc_i(ex_pc_i), .ex_state_i(ex_state_i),
    .ex_taken_i(ex_taken_i), .ex_pcplus4_i(ex_pcplus4_i), .ex_target_i(ex_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .br_count_o(br_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0] st;
  logic [1:0] exp_in  [3] = '{2'b01, 2'b10, 2'b11};
  logic [1:0] exp_out [3] = '{2'b10, 2'b11, 2'b11};
  logic       exp_mis [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    rst_i = 1'b1; id_branch_i = 1'b0; id_pc_i = 32'h0;
    ex_branch_i = 1'b0; ex_pc_i = 32'h0; ex_state_i = 2'b00; ex_taken_i = 1'b0;
    ex_pcplus4_i = 32'h0; ex_target_i = 32'h0;
    step(); step();
    rst_i = 1'b0;

    // reset state
    id_branch_i = 1'b1; id_pc_i = 32'h40;
    #1;
    check("rst_state", id_state_o, 2'b01);
    check("rst_pred", id_pred_taken_o, 1'b0);
    check("rst_br", br_count_o, 0);
    check("rst_miss", miss_count_o, 0);
    check("rst_mis", mispredict_o, 1'b0);

    // train pc 0x40 taken three times, feeding back the ID read
    for (int i = 0; i < 3; i++) begin
      id_pc_i = 32'h40; ex_branch_i = 1'b0;
      #1;
      st = id_state_o;
      check($sformatf("t2_in%0d", i), st, exp_in[i]);
      ex_branch_i = 1'b1; ex_pc_i = 32'h40; ex_state_i = st; ex_taken_i = 1'b1;
      ex_pcplus4_i = 32'h44; ex_target_i = 32'h100;
      #1;
      check($sformatf("t2_mis%0d", i), mispredict_o, exp_mis[i]);
      if (i == 0) check("t2_redir", redirect_pc_o, 32'h100);
      step();
      ex_branch_i = 1'b0;
      #1;
      check($sformatf("t2_out%0d", i), id_state_o, exp_out[i]);
    end
    check("t2_br", br_count_o, 3);
    check("t2_miss", miss_count_o, 1);

    // strong-taken resolved not taken
    ex_branch_i = 1'b1; ex_pc_i = 32'h40; ex_state_i = 2'b11; ex_taken_i = 1'b0;
    ex_pcplus4_i = 32'h44; ex_target_i = 32'h100;
    #1;
    check("t3_mis", mispredict_o, 1'b1);
    check("t3_redir", redirect_pc_o, 32'h44);
    step();
    ex_branch_i = 1'b0;
    #1;
    check("t3_state", id_state_o, 2'b10);
    check("t3_br", br_count_o, 4);
    check("t3_miss", miss_count_o, 2);

    // same-cycle bypass on pc 0x80 (aliases 0x40), other entry unaffected
    ex_branch_i = 1'b1; ex_pc_i = 32'h80; ex_state_i = 2'b01; ex_taken_i = 1'b1;
    ex_target_i = 32'h200; ex_pcplus4_i = 32'h84;
    id_pc_i = 32'h80;
    #1;
    check("t4_bypass", id_state_o, 2'b10);
    check("t4_mis", mispredict_o, 1'b1);
    check("t4_redir", redirect_pc_o, 32'h200);
    id_pc_i = 32'h44;
    #1;
    check("t4_nobyp", id_state_o, 2'b01);
    step();
    ex_branch_i = 1'b0; id_pc_i = 32'h40;
    #1;
    check("t5_alias", id_state_o, 2'b10);
    check("t4_br", br_count_o, 5);
    check("t4_miss", miss_count_o, 3);

    // prediction gating by id_branch_i
    id_branch_i = 1'b0;
    #1;
    check("t5_gate0", id_pred_taken_o, 1'b0);
    id_branch_i = 1'b1;
    #1;
    check("t5_gate1", id_pred_taken_o, 1'b1);

    // 0x44 saturate low, independent of 0x40
    ex_branch_i = 1'b1; ex_pc_i = 32'h44; ex_state_i = 2'b00; ex_taken_i = 1'b0;
    #1;
    check("t5_mis_sat", mispredict_o, 1'b0);
    step();
    ex_branch_i = 1'b0; id_pc_i = 32'h44;
    #1;
    check("t5_sat", id_state_o, 2'b00);
    id_pc_i = 32'h40;
    #1;
    check("t5_indep", id_state_o, 2'b10);

    // idle cycles change nothing
    ex_pc_i = 32'h40; ex_state_i = 2'b01; ex_taken_i = 1'b1;
    #1;
    check("t5_idle_mis", mispredict_o, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("t5_idle_state", id_state_o, 2'b10);
    check("t5_idle_br", br_count_o, 6);
    check("t5_idle_miss", miss_count_o, 3);

    // reset overrides a concurrent update
    ex_branch_i = 1'b1; ex_pc_i = 32'h40; ex_state_i = 2'b01; ex_taken_i = 1'b1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; ex_branch_i = 1'b0;
    id_pc_i = 32'h40;
    #1;
    check("t6_s40", id_state_o, 2'b01);
    id_pc_i = 32'h44;
    #1;
    check("t6_s44", id_state_o, 2'b01);
    id_pc_i = 32'h3C;
    #1;
    check("t6_s3c", id_state_o, 2'b01);
    check("t6_br", br_count_o, 0);
    check("t6_miss", miss_count_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
